// File: rtl/vdg_pixel_shifter.sv
// Video pixel shifter: captures each fetched video byte, looks up the font row in alpha mode
// and serialises the result into 4-bit palette indices, one per PixelEn strobe.
module vdg_pixel_shifter #(
  parameter int unsigned FONT_LAT = 1,
  parameter int unsigned SG_SPLIT = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PixelEn,
  input  logic       Load,
  input  logic       Active,
  input  logic       BackPorch,
  input  logic [7:0] DD,
  input  logic       AnG,
  input  logic       AnS,
  input  logic       InV,
  input  logic       CSS,
  input  logic [2:0] GMode,
  input  logic [3:0] AlphaRow,
  output logic [9:0] FontAddr,
  input  logic [7:0] FontData,
  output logic [3:0] Colour
);

  if (FONT_LAT != 1) begin : gen_font_lat_check
    $error("vdg_pixel_shifter: only FONT_LAT == 1 is supported");
  end

  localparam logic [3:0] SgSplit = 4'(SG_SPLIT);

  logic unused_gmode;
  assign unused_gmode = ^GMode[2:1];

  // Stage A: captured byte and mode
  logic       a_valid_q, a_valid_d;
  logic [7:0] a_dd_q, a_dd_d;
  logic       a_ang_q, a_ang_d, a_ans_q, a_ans_d, a_inv_q, a_inv_d;
  logic       a_css_q, a_css_d, a_gm0_q, a_gm0_d;
  logic [3:0] a_row_q, a_row_d;
  logic       a_act_q, a_act_d, a_bp_q, a_bp_d;

  // Stage B: shifter and the mode it was loaded with
  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       b_ang_q, b_ang_d, b_ans_q, b_ans_d, b_css_q, b_css_d, b_gm0_q, b_gm0_d;
  logic [2:0] b_fg_q, b_fg_d;
  logic       b_act_q, b_act_d, b_bp_q, b_bp_d;

  logic [9:0] font_addr_q, font_addr_d;
  logic [3:0] colour_q, colour_d;

  logic       b_2bpp, a_2bpp;
  logic       px1;
  logic [1:0] px2;
  logic [1:0] sg_sel;
  logic [7:0] src;
  logic [3:0] pix_colour;

  assign b_2bpp = b_ang_q & ~b_gm0_q;
  assign a_2bpp = a_ang_q & ~a_gm0_q;
  assign px1    = (cnt_q != 4'd0) & sr_q[7];
  assign px2    = (cnt_q != 4'd0) ? sr_q[7:6] : 2'b00;
  assign sg_sel = (a_row_q < SgSplit) ? a_dd_q[3:2] : a_dd_q[1:0];

  always_comb begin
    if (a_ang_q) begin
      src = a_dd_q;
    end else if (a_ans_q) begin
      src = {{4{sg_sel[1]}}, {4{sg_sel[0]}}};
    end else begin
      src = FontData ^ {8{a_inv_q}};
    end
  end

  always_comb begin
    if (b_2bpp) begin
      pix_colour = {1'b0, b_css_q, px2};
    end else if (b_ang_q) begin
      pix_colour = px1 ? (b_css_q ? 4'd4 : 4'd0) : (b_css_q ? 4'd8 : 4'd9);
    end else if (b_ans_q) begin
      pix_colour = px1 ? {1'b0, b_fg_q} : 4'd8;
    end else begin
      pix_colour = px1 ? (b_css_q ? 4'd7 : 4'd0) : (b_css_q ? 4'd10 : 4'd9);
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_dd_d    = a_dd_q;
    a_ang_d   = a_ang_q;
    a_ans_d   = a_ans_q;
    a_inv_d   = a_inv_q;
    a_css_d   = a_css_q;
    a_gm0_d   = a_gm0_q;
    a_row_d   = a_row_q;
    a_act_d   = a_act_q;
    a_bp_d    = a_bp_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    b_ang_d   = b_ang_q;
    b_ans_d   = b_ans_q;
    b_css_d   = b_css_q;
    b_gm0_d   = b_gm0_q;
    b_fg_d    = b_fg_q;
    b_act_d   = b_act_q;
    b_bp_d    = b_bp_q;
    font_addr_d = font_addr_q;
    colour_d    = colour_q;

    if (PixelEn) begin
      if (b_bp_q) begin
        colour_d = 4'd8;
      end else if (!b_act_q) begin
        // Border follows the live mode inputs, not the latched byte
        colour_d = AnG ? {1'b0, CSS, 2'b00} : 4'd8;
      end else begin
        colour_d = pix_colour;
        sr_d     = b_2bpp ? {sr_q[5:0], 2'b00} : {sr_q[6:0], 1'b0};
        cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
      end

      // A new transfer overrides any remaining pixels of the previous byte
      if (a_valid_q) begin
        sr_d      = src;
        cnt_d     = a_2bpp ? 4'd4 : 4'd8;
        b_ang_d   = a_ang_q;
        b_ans_d   = a_ans_q;
        b_css_d   = a_css_q;
        b_gm0_d   = a_gm0_q;
        b_fg_d    = a_dd_q[6:4];
        b_act_d   = a_act_q;
        b_bp_d    = a_bp_q;
        a_valid_d = 1'b0;
      end

      if (Load) begin
        a_valid_d   = 1'b1;
        a_dd_d      = DD;
        a_ang_d     = AnG;
        a_ans_d     = AnS;
        a_inv_d     = InV;
        a_css_d     = CSS;
        a_gm0_d     = GMode[0];
        a_row_d     = AlphaRow;
        a_act_d     = Active;
        a_bp_d      = BackPorch;
        font_addr_d = {DD[5:0], AlphaRow};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_valid_q   <= 1'b0;
      a_dd_q      <= '0;
      a_ang_q     <= 1'b0;
      a_ans_q     <= 1'b0;
      a_inv_q     <= 1'b0;
      a_css_q     <= 1'b0;
      a_gm0_q     <= 1'b0;
      a_row_q     <= '0;
      a_act_q     <= 1'b0;
      a_bp_q      <= 1'b1;
      sr_q        <= '0;
      cnt_q       <= '0;
      b_ang_q     <= 1'b0;
      b_ans_q     <= 1'b0;
      b_css_q     <= 1'b0;
      b_gm0_q     <= 1'b0;
      b_fg_q      <= '0;
      b_act_q     <= 1'b0;
      b_bp_q      <= 1'b1;
      font_addr_q <= '0;
      colour_q    <= 4'd8;
    end else begin
      a_valid_q   <= a_valid_d;
      a_dd_q      <= a_dd_d;
      a_ang_q     <= a_ang_d;
      a_ans_q     <= a_ans_d;
      a_inv_q     <= a_inv_d;
      a_css_q     <= a_css_d;
      a_gm0_q     <= a_gm0_d;
      a_row_q     <= a_row_d;
      a_act_q     <= a_act_d;
      a_bp_q      <= a_bp_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      b_ang_q     <= b_ang_d;
      b_ans_q     <= b_ans_d;
      b_css_q     <= b_css_d;
      b_gm0_q     <= b_gm0_d;
      b_fg_q      <= b_fg_d;
      b_act_q     <= b_act_d;
      b_bp_q      <= b_bp_d;
      font_addr_q <= font_addr_d;
      colour_q    <= colour_d;
    end
  end

  assign FontAddr = font_addr_q;
  assign Colour   = colour_q;

endmodule

// File: tb/tb_vdg_pixel_shifter.sv
// Bench for vdg_pixel_shifter: byte-level reference model checked every cycle, plus directed
// sequences with hand-computed colour lists.
module tb_vdg_pixel_shifter;

  localparam int SgSplit = 6;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       PixelEn = 1'b0;
  logic       Load = 1'b0;
  logic       Active = 1'b0;
  logic       BackPorch = 1'b1;
  logic [7:0] DD = '0;
  logic       AnG = 1'b0;
  logic       AnS = 1'b0;
  logic       InV = 1'b0;
  logic       CSS = 1'b0;
  logic [2:0] GMode = '0;
  logic [3:0] AlphaRow = '0;
  logic [9:0] FontAddr;
  logic [7:0] FontData = '0;
  logic [3:0] Colour;

  int n_chk = 0;
  int n_fail = 0;

  vdg_pixel_shifter #(
    .FONT_LAT (1),
    .SG_SPLIT (SgSplit)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PixelEn   (PixelEn),
    .Load      (Load),
    .Active    (Active),
    .BackPorch (BackPorch),
    .DD        (DD),
    .AnG       (AnG),
    .AnS       (AnS),
    .InV       (InV),
    .CSS       (CSS),
    .GMode     (GMode),
    .AlphaRow  (AlphaRow),
    .FontAddr  (FontAddr),
    .FontData  (FontData),
    .Colour    (Colour)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom(logic [9:0] a);
    if (a == 10'h013) return 8'h3C;
    return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
  endfunction

  // Registered font ROM: data follows the address by one Clk
  always @(posedge Clk) FontData <= rom(FontAddr);

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] dd;
    logic       ang, ans, inv, css, gm0;
    logic [3:0] row;
    logic       act, bp;
  } rec_t;

  rec_t       a_rec, b_rec;
  bit         a_valid;
  bit         model_on = 1'b0;
  int         pix_q[$];
  int         exp_col = 8;
  logic [9:0] exp_fa = '0;

  function automatic int bg_colour(rec_t r);
    if (r.ang) return r.gm0 ? (r.css ? 8 : 9) : (r.css ? 4 : 0);
    if (r.ans) return 8;
    return r.css ? 10 : 9;
  endfunction

  function automatic void fill(rec_t r, logic [7:0] fd);
    logic [7:0] v;
    logic [1:0] sel;
    pix_q.delete();
    if (r.ang && !r.gm0) begin
      for (int i = 0; i < 4; i++)
        pix_q.push_back((r.css ? 4 : 0) + int'((r.dd >> (6 - 2 * i)) & 8'd3));
    end else if (r.ang) begin
      for (int i = 0; i < 8; i++)
        pix_q.push_back(r.dd[7-i] ? (r.css ? 4 : 0) : (r.css ? 8 : 9));
    end else if (r.ans) begin
      sel = (int'(r.row) < SgSplit) ? r.dd[3:2] : r.dd[1:0];
      for (int i = 0; i < 8; i++)
        pix_q.push_back(((i < 4) ? sel[1] : sel[0]) ? int'(r.dd[6:4]) : 8);
    end else begin
      v = fd ^ {8{r.inv}};
      for (int i = 0; i < 8; i++)
        pix_q.push_back(v[7-i] ? (r.css ? 7 : 0) : (r.css ? 10 : 9));
    end
  endfunction

  initial forever begin
    @(posedge Clk);
    if (Reset) begin
      model_on = 1'b1;
      a_valid  = 1'b0;
      a_rec    = '0;
      a_rec.bp = 1'b1;
      b_rec    = a_rec;
      pix_q.delete();
      exp_col  = 8;
      exp_fa   = '0;
    end else if (PixelEn) begin
      if (b_rec.bp) exp_col = 8;
      else if (!b_rec.act) exp_col = AnG ? (CSS ? 4 : 0) : 8;
      else if (pix_q.size() > 0) exp_col = pix_q.pop_front();
      else exp_col = bg_colour(b_rec);
      if (a_valid) begin
        b_rec = a_rec;
        fill(a_rec, FontData);
        a_valid = 1'b0;
      end
      if (Load) begin
        a_rec   = '{DD, AnG, AnS, InV, CSS, GMode[0], AlphaRow, Active, BackPorch};
        a_valid = 1'b1;
        exp_fa  = {DD[5:0], AlphaRow};
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (model_on) begin
      chk("model_colour", int'(Colour), exp_col);
      chk("model_fontaddr", int'(FontAddr), int'(exp_fa));
    end
  end

  // ---------------- directed helpers ----------------
  // One PixelEn strobe followed by an idle Clk; returns at a negedge.
  task automatic pix(input logic ld);
    PixelEn = 1'b1;
    Load    = ld;
    @(posedge Clk);
    @(negedge Clk);
    PixelEn = 1'b0;
    Load    = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic byte8(input string nm, input logic [7:0] d, input int e [8]);
    DD = d;
    pix(1'b1);
    chk({nm, "_fontaddr"}, int'(FontAddr), int'({d[5:0], AlphaRow}));
    pix(1'b0);
    for (int i = 0; i < 8; i++) begin
      pix(1'b0);
      chk(nm, int'(Colour), e[i]);
    end
  endtask

  initial begin
    int trunc_exp [12];
    trunc_exp = '{0, 9, 0, 9, 9, 9, 9, 9, 0, 0, 0, 0};

    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // Idle after reset: blanked, no font address
    for (int i = 0; i < 5; i++) begin
      pix(1'b0);
      chk("reset_colour", int'(Colour), 8);
      chk("reset_fontaddr", int'(FontAddr), 0);
    end

    // Colour graphics, CSS=1, reloaded every 4th strobe
    AnG = 1'b1; GMode = 3'b000; CSS = 1'b1; Active = 1'b1; BackPorch = 1'b0; DD = 8'h1B;
    for (int j = 0; j < 12; j++) begin
      pix((j % 4) == 0);
      if (j >= 2) chk("cg4", int'(Colour), 4 + ((j - 2) % 4));
    end

    // Resolution graphics, full byte then background
    GMode = 3'b001; CSS = 1'b0;
    byte8("rg_full", 8'hA5, '{0, 9, 0, 9, 9, 0, 9, 0});
    pix(1'b0);
    chk("rg_bg", int'(Colour), 9);

    // Second load 4 strobes later truncates the first byte
    for (int j = 0; j < 14; j++) begin
      DD = (j < 4) ? 8'hA5 : 8'h0F;
      pix(j == 0 || j == 4);
      if (j >= 2) chk("rg_trunc", int'(Colour), trunc_exp[j-2]);
    end

    // Alpha internal font
    AnG = 1'b0; AnS = 1'b0; AlphaRow = 4'd3; InV = 1'b0; CSS = 1'b0;
    byte8("alpha", 8'h01, '{9, 9, 0, 0, 0, 0, 9, 9});
    InV = 1'b1;
    byte8("alpha_inv", 8'h01, '{0, 0, 9, 9, 9, 9, 0, 0});

    // Semigraphics-4, upper and lower quadrant pairs
    InV = 1'b0; AnS = 1'b1; AlphaRow = 4'd2;
    byte8("sg4_upper", 8'h3A, '{3, 3, 3, 3, 8, 8, 8, 8});
    AlphaRow = 4'd7;
    byte8("sg4_lower", 8'h3A, '{3, 3, 3, 3, 8, 8, 8, 8});

    // Border, then reset mid-byte without PixelEn
    Active = 1'b0; BackPorch = 1'b0; AnG = 1'b1; CSS = 1'b1; GMode = 3'b000;
    pix(1'b1); pix(1'b0); pix(1'b0);
    chk("border", int'(Colour), 4);
    Active = 1'b1; DD = 8'hE4;
    pix(1'b1); pix(1'b0); pix(1'b0);
    chk("pre_reset", int'(Colour), 7);
    pix(1'b0);
    chk("pre_reset", int'(Colour), 6);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("midbyte_reset_colour", int'(Colour), 8);
    chk("midbyte_reset_fontaddr", int'(FontAddr), 0);
    Reset = 1'b0;

    // Randomised traffic against the model; PixelEn never on consecutive Clks
    for (int c = 0; c < 4000; c++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      PixelEn   = !PixelEn && ($urandom_range(0, 3) != 0);
      Load      = ($urandom_range(0, 2) == 0);
      Active    = ($urandom_range(0, 9) != 0);
      BackPorch = ($urandom_range(0, 9) == 0);
      DD        = 8'($urandom);
      AnG       = 1'($urandom);
      AnS       = 1'($urandom);
      InV       = 1'($urandom);
      CSS       = 1'($urandom);
      GMode     = 3'($urandom);
      AlphaRow  = 4'($urandom_range(0, 11));
      @(posedge Clk);
      @(negedge Clk);
    end
    Reset   = 1'b0;
    PixelEn = 1'b0;
    Load    = 1'b0;
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
